ts_packet_mux: RTL and testbench

- Sits downstream of the four per-channel reclock/packet-prepare stages in the 4-channel tuner and shares their SYS_CLK domain.
- Polls each channel's "full packet available" flag in round-robin order and issues a one-cycle packet request to the selected channel.
- Captures the 188-byte TS packet that channel then streams, and re-emits it as one serial byte stream with sync, valid and channel tag.
- Checks the 0x47 sync byte of every packet and counts errors.

---
 rtl/ts_pkg.sv | 20 ++
 rtl/rr_arbiter4.sv | 29 ++
 rtl/ts_packet_mux.sv | 143 ++++++++++++++
 tb/tb_ts_packet_mux.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants and types for the transport-stream packet multiplexer.
package ts_pkg;

    localparam int         TS_N_CH      = 4;
    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, XFER, GAP} state_t;

    typedef struct packed {
        logic [7:0] dat;
        logic       vld;
        logic       sync;
        ch_idx_t    ch;
        logic       err;
    } ts_out_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Round-robin pick of the first requesting channel at or after the pointer.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter4
    import ts_pkg::*;
(
    input  logic [TS_N_CH-1:0] req_i,
    input  ch_idx_t            ptr_i,
    output ch_idx_t            gnt_idx_o,
    output logic               gnt_vld_o
);

    ch_idx_t cand;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx_o = ptr_i;
        gnt_vld_o = 1'b0;
        cand      = ptr_i;
        for (int i = TS_N_CH - 1; i >= 0; i--) begin
            cand = ptr_i + ch_idx_t'(i);
            if (req_i[cand]) begin
                gnt_idx_o = cand;
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_packet_mux.sv
// Polls four channels round-robin, requests one TS packet and re-emits it as a tagged byte stream.
// Latency: first output byte RD_LATENCY+1 cycles after the request pulse; 188 back-to-back bytes.
// Backpressure: OUT_READY gates only the start of a packet; a granted packet always completes.
module ts_packet_mux
    import ts_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int MIN_GAP    = 3
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic [3:0]  GOT_FULL_PACKET,
    input  logic [31:0] DATA_IN,
    input  logic        OUT_READY,
    output logic [3:0]  GIVE_ME_ONE_PACKET,
    output logic [7:0]  TS_DATA,
    output logic        TS_VALID,
    output logic        TS_SYNC,
    output logic [1:0]  TS_CH,
    output logic        SYNC_ERR,
    output logic [15:0] ERR_CNT
);

    state_t      state_q, state_d;
    ch_idx_t     ch_sel_q, ch_sel_d;
    ch_idx_t     ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    ts_out_t     out_q, out_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    ch_idx_t     arb_idx;
    logic        arb_vld;
    logic        start_ok;
    logic        first_byte;
    logic [7:0]  byte_in;

    rr_arbiter4 u_arb (
        .req_i     (GOT_FULL_PACKET),
        .ptr_i     (ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    assign start_ok   = OUT_READY && arb_vld;
    assign byte_in    = DATA_IN[{ch_sel_q, 3'b000} +: 8];
    assign first_byte = (state_q == XFER) && (cnt_q == 8'd0);

    // One counter serves WAIT, XFER and GAP; it is always zero on entry to each.
    always_comb begin
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d  = REQ;
                    ch_sel_d = arb_idx;
                end
            end
            REQ: begin
                cnt_d   = 8'd0;
                state_d = (RD_LATENCY == 1) ? XFER : WAIT;
            end
            WAIT: begin
                if (cnt_q == 8'(RD_LATENCY - 2)) begin
                    state_d = XFER;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            XFER: begin
                if (cnt_q == 8'(TS_PKT_LEN - 1)) begin
                    state_d = GAP;
                    cnt_d   = 8'd0;
                    ptr_d   = ch_sel_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                // Arbitrate in the last gap cycle so back-to-back requests keep the minimum period.
                if (cnt_q == 8'(MIN_GAP - 1)) begin
                    cnt_d = 8'd0;
                    if (start_ok) begin
                        state_d  = REQ;
                        ch_sel_d = arb_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d      = out_q;
        out_d.vld  = (state_q == XFER);
        out_d.sync = first_byte;
        out_d.err  = first_byte && (byte_in != TS_SYNC_BYTE);
        if (state_q == XFER) begin
            out_d.dat = byte_in;
        end
        if (first_byte) begin
            out_d.ch = ch_sel_q;
        end
        err_cnt_d = err_cnt_q;
        if (out_d.err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            ch_sel_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_sel_q  <= ch_sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign GIVE_ME_ONE_PACKET = (state_q == REQ) ? (4'b0001 << ch_sel_q) : 4'b0000;
    assign TS_DATA            = out_q.dat;
    assign TS_VALID           = out_q.vld;
    assign TS_SYNC            = out_q.sync;
    assign TS_CH              = out_q.ch;
    assign SYNC_ERR           = out_q.err;
    assign ERR_CNT            = err_cnt_q;

endmodule

// File: tb/tb_ts_packet_mux.sv
// Directed bench: channel models answer requests, a scoreboard queue checks every output byte.
module tb_ts_packet_mux;

    localparam int RD_LAT = 2;
    localparam int PKT    = 188;
    localparam int PERIOD = 193;

    typedef struct {
        int          cyc;
        logic [7:0]  dat;
        logic        sync;
        logic [1:0]  ch;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int cyc;
        int ch;
    } req_t;

    logic        SYS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  GOT_FULL_PACKET = 4'b0000;
    logic [31:0] DATA_IN = 32'h0;
    logic        OUT_READY = 1'b0;
    logic [3:0]  GIVE_ME_ONE_PACKET;
    logic [7:0]  TS_DATA;
    logic        TS_VALID;
    logic        TS_SYNC;
    logic [1:0]  TS_CH;
    logic        SYNC_ERR;
    logic [15:0] ERR_CNT;

    exp_t        sb[$];
    req_t        req_log[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          avail[4] = '{default: 0};
    int          start[4] = '{default: -1000};
    logic [7:0]  first_b[4] = '{default: 8'h47};
    logic [15:0] exp_cnt = 16'h0;
    exp_t        mon_e;
    int          t_req;
    int          t_rdy;

    ts_packet_mux #(.RD_LATENCY(RD_LAT), .MIN_GAP(3)) dut (
        .SYS_CLK            (SYS_CLK),
        .RST                (RST),
        .GOT_FULL_PACKET    (GOT_FULL_PACKET),
        .DATA_IN            (DATA_IN),
        .OUT_READY          (OUT_READY),
        .GIVE_ME_ONE_PACKET (GIVE_ME_ONE_PACKET),
        .TS_DATA            (TS_DATA),
        .TS_VALID           (TS_VALID),
        .TS_SYNC            (TS_SYNC),
        .TS_CH              (TS_CH),
        .SYNC_ERR           (SYNC_ERR),
        .ERR_CNT            (ERR_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    function automatic logic [7:0] pkt_byte(input int k, input int i);
        if (i == 0) return first_b[k];
        return 8'(i) ^ 8'(k << 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SYS_CLK);
        #2;
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int b = 0;
        while (req_log.size() < n && b < budget) begin
            tick(1);
            b++;
        end
        chk("request_count", req_log.size(), n);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (sb.size() > 0 && b < budget) begin
            tick(1);
            b++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        tick(6);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_give"}, GIVE_ME_ONE_PACKET, 0);
        chk({tag, "_ts_data"}, TS_DATA, 0);
        chk({tag, "_ts_valid"}, TS_VALID, 0);
        chk({tag, "_ts_sync"}, TS_SYNC, 0);
        chk({tag, "_ts_ch"}, TS_CH, 0);
        chk({tag, "_sync_err"}, SYNC_ERR, 0);
        chk({tag, "_err_cnt"}, ERR_CNT, 0);
    endtask

    // Upstream channel models: answer a request with 188 bytes RD_LAT cycles later.
    initial begin
        exp_t e;
        req_t r;
        forever begin
            @(negedge SYS_CLK);
            if (RST) begin
                for (int k = 0; k < 4; k++) start[k] = -1000;
            end else begin
                if (GIVE_ME_ONE_PACKET != 4'b0000)
                    chk("request_onehot", $countones(GIVE_ME_ONE_PACKET), 1);
                for (int k = 0; k < 4; k++) begin
                    if (GIVE_ME_ONE_PACKET[k]) begin
                        r.cyc = cyc;
                        r.ch  = k;
                        req_log.push_back(r);
                        if (avail[k] > 0) avail[k]--;
                        start[k] = cyc + RD_LAT;
                        if (first_b[k] != 8'h47 && exp_cnt != 16'hFFFF) exp_cnt++;
                        for (int i = 0; i < PKT; i++) begin
                            e.cyc  = cyc + RD_LAT + 1 + i;
                            e.dat  = pkt_byte(k, i);
                            e.sync = (i == 0);
                            e.ch   = 2'(k);
                            e.err  = (i == 0) && (first_b[k] != 8'h47);
                            e.cnt  = exp_cnt;
                            sb.push_back(e);
                        end
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (cyc >= start[k] && cyc < start[k] + PKT)
                    DATA_IN[8*k +: 8] = pkt_byte(k, cyc - start[k]);
                else
                    DATA_IN[8*k +: 8] = 8'hEE;
                GOT_FULL_PACKET[k] = (avail[k] > 0);
            end
        end
    end

    // Monitor: every valid output byte must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge SYS_CLK);
            if (TS_VALID) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got dat=%h with no packet outstanding (cycle %0d)", TS_DATA, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.cyc || TS_DATA !== mon_e.dat || TS_SYNC !== mon_e.sync ||
                        TS_CH !== mon_e.ch || SYNC_ERR !== mon_e.err || ERR_CNT !== mon_e.cnt) begin
                        n_err++;
                        $display("FAIL stream_byte: got cyc=%0d dat=%h sync=%b ch=%0d err=%b cnt=%h, required cyc=%0d dat=%h sync=%b ch=%0d err=%b cnt=%h",
                                 cyc, TS_DATA, TS_SYNC, TS_CH, SYNC_ERR, ERR_CNT,
                                 mon_e.cyc, mon_e.dat, mon_e.sync, mon_e.ch, mon_e.err, mon_e.cnt);
                    end
                end
            end else if (TS_SYNC || SYNC_ERR) begin
                n_cmp++;
                n_err++;
                $display("FAIL strobe_without_valid: got sync=%b err=%b, required 0 0", TS_SYNC, SYNC_ERR);
            end
        end
    end

    initial begin
        tick(3);
        chk_all_zero("in_reset");
        RST = 1'b0;
        tick(2);
        chk_all_zero("after_reset");

        // All four channels ready: strict 0,1,2,3 order at the minimum period.
        OUT_READY = 1'b1;
        req_log.delete();
        for (int k = 0; k < 4; k++) avail[k] = 1;
        wait_reqs(4, 1000);
        drain(400);
        if (req_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", req_log[i].ch, i);
            for (int i = 1; i < 4; i++) chk("rr_period", req_log[i].cyc - req_log[i-1].cyc, PERIOD);
        end

        // Single channel 2 packet: exactly one request.
        req_log.delete();
        avail[2] = 1;
        wait_reqs(1, 300);
        drain(300);
        tick(200);
        chk("single_req_count", req_log.size(), 1);
        if (req_log.size() > 0) chk("single_req_ch", req_log[0].ch, 2);
        chk("single_err_cnt", ERR_CNT, 0);

        // Pointer wrap: serve 3, then flags 1001 must pick 0 before 3.
        req_log.delete();
        avail[3] = 1;
        wait_reqs(1, 300);
        drain(300);
        avail[0] = 1;
        avail[3] = 1;
        wait_reqs(3, 700);
        drain(300);
        if (req_log.size() == 3) begin
            chk("wrap_first", req_log[0].ch, 3);
            chk("wrap_second", req_log[1].ch, 0);
            chk("wrap_third", req_log[2].ch, 3);
        end

        // Bad sync byte on channel 1, then saturation from a preloaded counter.
        first_b[1] = 8'h00;
        req_log.delete();
        avail[1] = 1;
        wait_reqs(1, 300);
        drain(300);
        chk("err_cnt_one", ERR_CNT, 16'h0001);
        force dut.err_cnt_q = 16'hFFFF;
        tick(2);
        release dut.err_cnt_q;
        exp_cnt = 16'hFFFF;
        req_log.delete();
        avail[1] = 1;
        wait_reqs(1, 300);
        drain(300);
        chk("err_cnt_saturated", ERR_CNT, 16'hFFFF);
        first_b[1] = 8'h47;

        // Reset at byte index 100 of a channel 3 packet.
        req_log.delete();
        avail[3] = 1;
        wait_reqs(1, 300);
        t_req = (req_log.size() > 0) ? req_log[0].cyc : cyc;
        while (cyc < t_req + RD_LAT + 100) tick(1);
        chk("valid_before_abort", TS_VALID, 1);
        RST = 1'b1;
        #1;
        chk_all_zero("abort");
        sb.delete();
        exp_cnt = 16'h0;
        tick(2);
        RST = 1'b0;
        req_log.delete();
        avail[1] = 1;
        avail[3] = 1;
        wait_reqs(2, 700);
        drain(300);
        if (req_log.size() == 2) begin
            chk("post_reset_first", req_log[0].ch, 1);
            chk("post_reset_second", req_log[1].ch, 3);
        end

        // OUT_READY gating and mid-packet drop.
        OUT_READY = 1'b0;
        req_log.delete();
        avail[2] = 1;
        tick(20);
        chk("no_req_not_ready", req_log.size(), 0);
        t_rdy = cyc;
        OUT_READY = 1'b1;
        wait_reqs(1, 50);
        if (req_log.size() > 0) begin
            chk("ready_to_req", req_log[0].cyc - t_rdy, 1);
            while (cyc < req_log[0].cyc + 50) tick(1);
        end
        OUT_READY = 1'b0;
        drain(300);
        chk("final_err_cnt", ERR_CNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
